rv_gated_reg: RTL and testbench

- Library-level clock-gated register primitive for the core's bus/bridge logic.
- Combines three elements:
  - a clock-gate header producing a gated clock `l1clk`;
  - an enable-qualified data register clocked by that gated clock;
  - an ungated pipeline register clocked every cycle.
- Used wherever wide, rarely-updated state (addresses, write data, command buffers) must hold value without toggling the clock tree.

---
 rtl/rv_gated_reg.sv | 93 +++++++++
 tb/tb_rv_gated_reg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_gated_reg.sv
// rv_gated_reg: latch-gated, enable-qualified register plus an ungated one-cycle pipeline copy.
// Define RV_CLKGATE_BYPASS_EN (FPGA) to drop the latch/gated clock and use a D-input enable mux.
module rv_gated_reg #(
  parameter int WIDTH = 32,
  parameter int SLICE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             scan_mode,
  input  logic             clk_override,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_raw,
  output logic             l1clk
);

  localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;

  logic [WIDTH-1:0] raw_r;

`ifdef RV_CLKGATE_BYPASS_EN
  logic unused_dft_s;
  assign unused_dft_s = scan_mode ^ clk_override;
`else
  logic gen_s;
  // rst keeps the gate open so a synchronous reset always reaches the flops
  assign gen_s = en | rst | scan_mode | clk_override;
`endif

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    localparam int LO = k * SLICE;
    localparam int HI = ((k + 1) * SLICE > WIDTH) ? (WIDTH - 1) : ((k + 1) * SLICE - 1);

    logic [HI-LO:0] q_r;
    logic           gclk_s;

`ifdef RV_CLKGATE_BYPASS_EN
    assign gclk_s = clk;

    // Slice register with the enable folded into the D input
    always_ff @(posedge clk) begin
      if (rst) begin
        q_r <= '0;
      end else if (en) begin
        q_r <= din[HI:LO];
      end else begin
        q_r <= q_r;
      end
    end
`else
    logic latch_q_r;

    // Gate latch: transparent only while clk is low, so gen glitches in the high phase cannot pulse
    always_latch begin
      if (!clk) begin
        latch_q_r = gen_s;
      end
    end

    assign gclk_s = clk & latch_q_r;

    // Slice register on the gated clock; the en mux holds value when the gate is forced open
    always_ff @(posedge gclk_s) begin
      if (rst) begin
        q_r <= '0;
      end else if (en) begin
        q_r <= din[HI:LO];
      end else begin
        q_r <= q_r;
      end
    end
`endif

    assign dout[HI:LO] = q_r;

    if (k == 0) begin : g_l1clk
      assign l1clk = gclk_s;
    end
  end

  // Ungated pipeline copy of din
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_r <= '0;
    end else begin
      raw_r <= din;
    end
  end

  assign dout_raw = raw_r;

endmodule

// File: tb/tb_rv_gated_reg.sv
// Self-checking bench for rv_gated_reg: scoreboard of expected dout/dout_raw plus l1clk edge counts.
// Works for both the gated build and the RV_CLKGATE_BYPASS_EN build.
module tb_rv_gated_reg;

`ifdef RV_CLKGATE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, scan_mode, clk_override;
  logic [31:0] din;
  wire  [31:0] dout, dout_raw;
  wire         l1clk;

  logic        rst72, en72, zero72;
  logic [71:0] din72;
  wire  [71:0] dout72, raw72;
  wire         l1clk72;

  rv_gated_reg #(.WIDTH(32), .SLICE(32)) dut (
    .clk(clk), .rst(rst), .en(en), .scan_mode(scan_mode), .clk_override(clk_override),
    .din(din), .dout(dout), .dout_raw(dout_raw), .l1clk(l1clk)
  );

  rv_gated_reg #(.WIDTH(72), .SLICE(32)) dut72 (
    .clk(clk), .rst(rst72), .en(en72), .scan_mode(zero72), .clk_override(zero72),
    .din(din72), .dout(dout72), .dout_raw(raw72), .l1clk(l1clk72)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] r;
  } exp_t;

  exp_t        q[$];
  logic [71:0] q72[$];
  logic [71:0] q72r[$];
  logic [31:0] m_dout, m_raw;
  logic [71:0] m72, m72r;
  int          n_checks = 0;
  int          n_fail = 0;
  int          l1_edges = 0;

  always @(posedge l1clk) l1_edges++;

  // Drive one cycle on the 32-bit instance and push the expected post-edge outputs.
  task automatic step(input logic r, input logic e, input logic so, input logic co, input logic [31:0] d);
    @(negedge clk);
    rst = r; en = e; scan_mode = so; clk_override = co; din = d;
    if (r) begin
      m_dout = '0;
      m_raw  = '0;
    end else begin
      if (e) m_dout = d;
      m_raw = d;
    end
    q.push_back({m_dout, m_raw});
    @(posedge clk);
    #1;
  endtask

  task automatic step72(input logic r, input logic e, input logic [71:0] d);
    @(negedge clk);
    rst72 = r; en72 = e; din72 = d;
    if (r) begin
      m72  = '0;
      m72r = '0;
    end else begin
      if (e) m72 = d;
      m72r = d;
    end
    q72.push_back(m72);
    q72r.push_back(m72r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   e0;
    e0 = l1_edges;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) e0 = l1_edges;
      step((i < 2) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      e = q.pop_front();
      n_checks++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL reset_dout[%0d]: got %h expected %h", i, dout, e.d);
      end
      n_checks++;
      if (dout_raw !== e.r) begin
        n_fail++;
        $display("FAIL reset_dout_raw[%0d]: got %h expected %h", i, dout_raw, e.r);
      end
      if (i == 1) begin
        n_checks++;
        if ((l1_edges - e0) != 1) begin
          n_fail++;
          $display("FAIL reset_l1clk_edges: got %0d expected 1", l1_edges - e0);
        end
      end
    end
  endtask

  task automatic test_load_hold();
    exp_t e;
    int   e0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_1234);
    e0 = l1_edges;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
      e = q.pop_front();
      n_checks++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL load_hold_dout[%0d]: got %h expected %h", i, dout, e.d);
      end
      n_checks++;
      if (dout_raw !== e.r) begin
        n_fail++;
        $display("FAIL load_hold_dout_raw[%0d]: got %h expected %h", i, dout_raw, e.r);
      end
    end
    n_checks++;
    if ((l1_edges - e0) != 5 * BYP) begin
      n_fail++;
      $display("FAIL hold_l1clk_edges: got %0d expected %0d", l1_edges - e0, 5 * BYP);
    end
  endtask

  task automatic test_override();
    exp_t e;
    int   e0;
    for (int g = 0; g < 2; g++) begin
      e0 = l1_edges;
      for (int i = 0; i < 4; i++) begin
        step(1'b0, 1'b0, (g == 1) ? 1'b1 : 1'b0, (g == 0) ? 1'b1 : 1'b0, $urandom());
        e = q.pop_front();
        n_checks++;
        if (dout !== e.d) begin
          n_fail++;
          $display("FAIL override_dout[%0d/%0d]: got %h expected %h", g, i, dout, e.d);
        end
        n_checks++;
        if (dout_raw !== e.r) begin
          n_fail++;
          $display("FAIL override_dout_raw[%0d/%0d]: got %h expected %h", g, i, dout_raw, e.r);
        end
      end
      n_checks++;
      if ((l1_edges - e0) != 4) begin
        n_fail++;
        $display("FAIL override_l1clk_edges[%0d]: got %0d expected 4", g, l1_edges - e0);
      end
    end
  endtask

  task automatic test_reset_vs_enable();
    exp_t e;
    logic [31:0] d [4] = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h1357_9BDF, 32'h2468_ACE0};
    logic        r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        en_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(r[i], en_v[i], 1'b0, 1'b0, d[i]);
      e = q.pop_front();
      n_checks++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL rst_vs_en_dout[%0d]: got %h expected %h", i, dout, e.d);
      end
      n_checks++;
      if (dout_raw !== e.r) begin
        n_fail++;
        $display("FAIL rst_vs_en_dout_raw[%0d]: got %h expected %h", i, dout_raw, e.r);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, $urandom());
      e = q.pop_front();
      n_checks++;
      if (dout !== e.d || dout !== dout_raw) begin
        n_fail++;
        $display("FAIL b2b_dout[%0d]: got %h expected %h (raw %h)", i, dout, e.d, dout_raw);
      end
      n_checks++;
      if (dout_raw !== e.r) begin
        n_fail++;
        $display("FAIL b2b_dout_raw[%0d]: got %h expected %h", i, dout_raw, e.r);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   e0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    e = q.pop_front();
    n_checks++;
    if (dout !== e.d) begin
      n_fail++;
      $display("FAIL glitch_load_dout: got %h expected %h", dout, e.d);
    end
    e0 = l1_edges;
    for (int i = 0; i < 4; i++) begin
      // clk is high here: pulse en and leave it low before the next falling edge
      #1 en = 1'b1;
      #1 en = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, $urandom());
      e = q.pop_front();
      n_checks++;
      if (dout !== e.d) begin
        n_fail++;
        $display("FAIL glitch_dout[%0d]: got %h expected %h", i, dout, e.d);
      end
      n_checks++;
      if (dout_raw !== e.r) begin
        n_fail++;
        $display("FAIL glitch_dout_raw[%0d]: got %h expected %h", i, dout_raw, e.r);
      end
    end
    n_checks++;
    if ((l1_edges - e0) != 4 * BYP) begin
      n_fail++;
      $display("FAIL glitch_l1clk_edges: got %0d expected %0d", l1_edges - e0, 4 * BYP);
    end
  endtask

  task automatic test_multi_slice();
    logic [71:0] ed, er;
    logic [71:0] d [6] = '{72'hFF_FFFF_FFFF_FFFF_FFFF, 72'hFF_FFFF_FFFF_FFFF_FFFF,
                           72'hAB_CDEF_0123_4567_89AB, 72'h54_3210_FEDC_BA98_7654,
                           72'h01_CDEF_0123_4567_89AB, 72'h00_0000_0000_0000_0000};
    logic        r [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        en_v [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step72(r[i], en_v[i], d[i]);
      ed = q72.pop_front();
      er = q72r.pop_front();
      n_checks++;
      if (dout72 !== ed) begin
        n_fail++;
        $display("FAIL slice72_dout[%0d]: got %h expected %h", i, dout72, ed);
      end
      n_checks++;
      if (raw72 !== er) begin
        n_fail++;
        $display("FAIL slice72_dout_raw[%0d]: got %h expected %h", i, raw72, er);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; scan_mode = 1'b0; clk_override = 1'b0; din = '0;
    rst72 = 1'b1; en72 = 1'b0; zero72 = 1'b0; din72 = '0;
    m_dout = '0; m_raw = '0; m72 = '0; m72r = '0;
    test_reset();
    test_load_hold();
    test_override();
    test_reset_vs_enable();
    test_back_to_back();
    test_glitch();
    test_multi_slice();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
